// File: rtl/posit_mult_issue_collect_pkg.sv
// Shared constants, result entry type and helpers for the posit multiplier
// issue/collect block.
package posit_mult_issue_collect_pkg;

  localparam int unsigned N       = 32;
  localparam int unsigned ES      = 6;
  localparam int unsigned MUL_LAT = 5;

  typedef struct packed {
    logic         inf;
    logic         zero;
    logic [N-1:0] data;
  } result_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/posit_result_fifo.sv
// First-word-fall-through result FIFO; push and pop may coincide at any occupancy.
module posit_result_fifo
  import posit_mult_issue_collect_pkg::*;
#(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head_data,
  output logic                    empty,
  output logic                    full,
  output logic [clog2(DEPTH):0]   count
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam logic [AW:0] DepthCount = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DepthCount);
  assign count   = count_q;
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign do_push = push & (~full | do_pop);

  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/posit_mult_issue_collect.sv
// Issues operand pairs to a non-backpressured posit multiplier under a credit
// scheme and collects its results in issue order.
module posit_mult_issue_collect #(
  parameter int unsigned N     = posit_mult_issue_collect_pkg::N,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LAT   = posit_mult_issue_collect_pkg::MUL_LAT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         mul_start,
  output logic [N-1:0] mul_in1,
  output logic [N-1:0] mul_in2,
  input  logic [N-1:0] mul_out,
  input  logic         mul_inf,
  input  logic         mul_zero,
  input  logic         mul_done,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_inf,
  output logic         out_zero,
  output logic         err,
  output logic         busy
);
  import posit_mult_issue_collect_pkg::*;

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned DW = clog2(LAT + 2);
  localparam int unsigned W  = N + 2;
  localparam logic [DW-1:0] DrainInit = DW'(LAT + 1);
  localparam logic [AW+1:0] DepthCredit = (AW + 2)'(DEPTH);

  logic [DW-1:0] drain_q, drain_d;
  logic [AW:0]   inflight_q, inflight_d;
  logic [AW:0]   count;
  logic [AW+1:0] credit;
  logic          mul_start_q;
  logic [N-1:0]  mul_in1_q, mul_in2_q;
  logic          err_q;
  logic          accept, counted_done, pop, err_hit, push;
  logic          empty, full;
  logic [W-1:0]  head;

  assign credit       = {1'b0, count} + {1'b0, inflight_q};
  assign in_ready     = (drain_q == '0) & (credit < DepthCredit);
  assign accept       = in_valid & in_ready;
  assign out_valid    = ~empty;
  assign pop          = out_valid & out_ready;
  // Results arriving inside the drain window belong to pre-reset operations.
  assign counted_done = mul_done & (drain_q == '0);
  assign err_hit      = counted_done & ((inflight_q == '0) | (full & ~pop));
  assign push         = counted_done & ~err_hit;

  always_comb begin
    drain_d = drain_q;
    if (drain_q != '0) drain_d = drain_q - 1'b1;
  end

  always_comb begin
    inflight_d = inflight_q;
    unique case ({accept, push})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_q     <= DrainInit;
      inflight_q  <= '0;
      mul_start_q <= 1'b0;
      mul_in1_q   <= '0;
      mul_in2_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      drain_q     <= drain_d;
      inflight_q  <= inflight_d;
      mul_start_q <= accept;
      if (accept) begin
        mul_in1_q <= in_a;
        mul_in2_q <= in_b;
      end
      err_q <= err_q | err_hit;
    end
  end

  posit_result_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({mul_inf, mul_zero, mul_out}),
    .pop       (pop),
    .head_data (head),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

  assign mul_start = mul_start_q;
  assign mul_in1   = mul_in1_q;
  assign mul_in2   = mul_in2_q;
  assign out_inf   = head[W-1];
  assign out_zero  = head[W-2];
  assign out_data  = head[N-1:0];
  assign err       = err_q;
  assign busy      = (inflight_q != '0) | ~empty | (drain_q != '0);

endmodule

// File: tb/tb_posit_mult_issue_collect.sv
// Directed bench for posit_mult_issue_collect with a fixed-latency multiplier model.
module tb_posit_mult_issue_collect;
  import posit_mult_issue_collect_pkg::*;

  localparam int unsigned Lat = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic        mul_start;
  logic [31:0] mul_in1, mul_in2, mul_out;
  logic        mul_inf, mul_zero, mul_done;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        out_inf, out_zero, err, busy;
  logic        inj;
  logic [31:0] inj_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  posit_mult_issue_collect #(
    .N     (32),
    .DEPTH (8),
    .LAT   (Lat)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_start (mul_start),
    .mul_in1   (mul_in1),
    .mul_in2   (mul_in2),
    .mul_out   (mul_out),
    .mul_inf   (mul_inf),
    .mul_zero  (mul_zero),
    .mul_done  (mul_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_inf   (out_inf),
    .out_zero  (out_zero),
    .err       (err),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Stand-in multiplier: 1.0 is the identity, zero and NaR propagate.
  function automatic result_t mul_model(input logic [31:0] a, input logic [31:0] b);
    result_t r;
    r.inf  = (a == 32'h8000_0000) | (b == 32'h8000_0000);
    r.zero = ~r.inf & ((a == 32'h0) | (b == 32'h0));
    if (r.inf)                   r.data = 32'h8000_0000;
    else if (r.zero)             r.data = 32'h0;
    else if (a == 32'h4000_0000) r.data = b;
    else if (b == 32'h4000_0000) r.data = a;
    else                         r.data = a ^ b;
    return r;
  endfunction

  // Unreset pipeline: sampled at the edge where mul_start is seen, done LAT cycles later.
  logic [34:0] pipe [Lat] = '{default: '0};
  always @(posedge clk) begin
    pipe[0] <= {mul_start, mul_model(mul_in1, mul_in2)};
    for (int i = 1; i < Lat; i++) pipe[i] <= pipe[i-1];
  end

  always_comb begin
    mul_done = pipe[Lat-1][34] | inj;
    mul_out  = inj ? inj_data : pipe[Lat-1][31:0];
    mul_inf  = ~inj & pipe[Lat-1][33];
    mul_zero = ~inj & pipe[Lat-1][32];
  end

  // Scoreboard: what the next edge will accept/pop, sampled just after the drive point.
  result_t exp_q[$];
  int acc_cnt = 0, pop_cnt = 0, cyc = 0, first_pop = -1, last_pop = -1;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    result_t e;
    #1;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (in_valid & in_ready) begin
        exp_q.push_back(mul_model(in_a, in_b));
        acc_cnt++;
      end
      if (out_valid & out_ready) begin
        pop_cnt++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        check("pop_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pop_order", {out_inf, out_zero, out_data}, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int base, pbase, nr, k, flag, done_cnt;
    in_valid = 0; in_a = 0; in_b = 0; out_ready = 0; inj = 0; inj_data = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_in", {mul_in1, mul_in2}, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", {out_inf, out_zero, out_data}, 0);
    check("rst_err", err, 0);

    // 1: drain window after release
    rst = 0;
    flag = 0;
    for (int i = 0; i < 6; i++) begin
      check("drain_in_ready", in_ready, 0);
      check("drain_busy", busy, 1);
      if (mul_start | err) flag = 1;
      @(negedge clk);
    end
    check("drain_start_err", flag, 0);
    check("drain_end_ready", in_ready, 1);

    // 2: single op, latency
    in_valid = 1; in_a = 32'h4000_0000; in_b = 32'h4000_0000;
    @(negedge clk);
    in_valid = 0;
    check("single_start", mul_start, 1);
    check("single_ops", {mul_in1, mul_in2}, {32'h4000_0000, 32'h4000_0000});
    @(negedge clk);
    check("single_start_once", mul_start, 0);
    flag = 0;
    for (int n = 2; n <= 6; n++) begin
      if (out_valid) flag = 1;
      @(negedge clk);
    end
    check("single_early", flag, 0);
    check("single_valid", out_valid, 1);
    check("single_out", {out_inf, out_zero, out_data}, {2'b00, 32'h4000_0000});
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("single_popped", out_valid, 0);
    check("single_pop_cnt", pop_cnt, 1);

    // 3: credit limit with stalled consumer
    base = acc_cnt; pbase = pop_cnt;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_a = 32'h4000_0000; in_b = 32'h4100_0000 + i;
      @(negedge clk);
    end
    in_valid = 0;
    repeat (10) @(negedge clk);
    check("full_accepts", acc_cnt - base, 8);
    check("full_in_ready", in_ready, 0);
    check("full_err", err, 0);
    check("full_out_valid", out_valid, 1);
    check("full_no_pop", pop_cnt - pbase, 0);
    out_ready = 1;
    for (k = 0; k < 40 && (pop_cnt - pbase) < 8; k++) @(negedge clk);
    check("full_drained", pop_cnt - pbase, 8);
    check("full_ready_back", in_ready, 1);
    check("full_empty", out_valid, 0);

    // 4: streaming with zero and NaR operands
    first_pop = -1; pbase = pop_cnt; nr = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1;
      if (i == 5) begin
        in_a = 32'h0; in_b = 32'h0;
      end else if (i == 10) begin
        in_a = 32'h8000_0000; in_b = 32'h4000_0000;
      end else begin
        in_a = 32'h4000_0000; in_b = 32'h5000_0000 + i;
      end
      if (!in_ready) nr++;
      @(negedge clk);
    end
    in_valid = 0;
    for (k = 0; k < 40 && (pop_cnt - pbase) < 20; k++) @(negedge clk);
    check("stream_pops", pop_cnt - pbase, 20);
    check("stream_stalls", nr, 0);
    check("stream_rate", last_pop - first_pop, 19);
    check("stream_err", err, 0);

    // 5: spurious done while idle
    repeat (10) @(negedge clk);
    check("idle_busy", busy, 0);
    inj = 1; inj_data = 32'h1234_5678;
    @(negedge clk);
    inj = 0;
    check("spur_err", err, 1);
    check("spur_no_push", out_valid, 0);
    repeat (5) @(negedge clk);
    check("spur_err_sticky", err, 1);
    check("spur_still_empty", out_valid, 0);

    // 6: reset with operations in flight
    out_ready = 1;
    base = acc_cnt;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_a = 32'h4000_0000; in_b = 32'h6000_0000 + i;
      @(negedge clk);
    end
    in_valid = 0;
    check("mid_accepts", acc_cnt - base, 3);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    pbase = pop_cnt; flag = 0; done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      check("mid_drain_ready", in_ready, 0);
      if (out_valid | err) flag = 1;
      if (mul_done) done_cnt++;
      @(negedge clk);
    end
    check("mid_dones_seen", done_cnt, 3);
    check("mid_ready_back", in_ready, 1);
    check("mid_err", err, 0);
    repeat (10) begin
      if (out_valid | err) flag = 1;
      @(negedge clk);
    end
    check("mid_dropped", flag, 0);
    check("mid_no_pop", pop_cnt - pbase, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/posit_mult_issue_collect.md
Name: posit_mult_issue_collect

Overview:
- Initiator/collector for the pipelined posit multiplier (N=32, es=6): takes operand pairs on a valid/ready input and drives the multiplier's start/in1/in2.
- Captures each done/out/inf/zero result into an ordered result FIFO and presents it on a valid/ready output.
- The multiplier has no backpressure, so the block issues an operation only when a FIFO slot is guaranteed for it (credit scheme).

Parameters:
- N, 32, posit width.
- DEPTH, 8, result FIFO entries; power of 2, at least 2.
- LAT, 5, cycles from the mul_start sample edge to the mul_done high cycle of the attached multiplier.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when in_valid & in_ready at posedge
- in_a  in  N  operand 1 (posit)
- in_b  in  N  operand 2 (posit)
- mul_start  out  1  start to multiplier, registered
- mul_in1  out  N  operand 1 to multiplier, registered
- mul_in2  out  N  operand 2 to multiplier, registered
- mul_out  in  N  multiplier result
- mul_inf  in  1  multiplier inf flag
- mul_zero  in  1  multiplier zero flag
- mul_done  in  1  multiplier result valid
- out_valid  out  1  result FIFO head valid
- out_ready  in  1  consumer pops head when out_valid & out_ready
- out_data  out  N  head result
- out_inf  out  1  head inf flag
- out_zero  out  1  head zero flag
- err  out  1  sticky protocol error
- busy  out  1  inflight != 0, or FIFO not empty, or drain != 0

Behaviour:
- Reset values: mul_start 0, mul_in1/mul_in2 0, FIFO empty (out_valid 0; out_data/inf/zero 0), inflight 0, err 0, drain = LAT+1.
  - in_ready and busy are derived from the reset state (0 and 1 respectively).
- Drain counter, width clog2(LAT+2):
  - Decrements by 1 each cycle while nonzero.
  - While nonzero: in_ready = 0, and mul_done is discarded with no FIFO push and no err.
  - This absorbs results from operations launched before a reset, since the multiplier itself is unreset.
- in_ready = (drain == 0) & (count + inflight < DEPTH).
  - count and inflight are each clog2(DEPTH)+1 bits wide.
  - A same-cycle pop is not credited, which is conservative.
- Issue: on accept, mul_in1/mul_in2 <= in_a/in_b and mul_start <= 1 at that edge; otherwise mul_start <= 0 and operands hold.
  - Throughput is one operation per cycle.
  - Accept-edge to mul_done-high is LAT+1 cycles.
- inflight: +1 on accept, -1 on a counted mul_done (drain == 0); both in the same cycle leaves it unchanged.
- Collect: a counted mul_done pushes {mul_inf, mul_zero, mul_out} at that edge.
  - out_valid rises the following cycle; the FIFO is first-word-fall-through.
  - Results leave in issue order.
- Simultaneous push and pop: allowed at any occupancy, including full; count is unchanged.
- Pointers wrap modulo DEPTH.
- Error: a counted mul_done with inflight == 0, or with count == DEPTH and no pop, sets err = 1 (sticky until rst).
  - In that case the entry is dropped, and count/inflight are unchanged.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). In-flight results are dropped by the drain window, with no err.
- The block never inspects posit contents; inf and zero are passed through unmodified.

Decomposition:
- Shared package holds:
  - constants N=32, ES=6, MUL_LAT=5;
  - typedef result entry {inf, zero, data[N-1:0]} (N+2 bits);
  - function clog2.
- Sub-module posit_result_fifo: synchronous FWFT FIFO with parameters WIDTH and DEPTH.
  - Ports: push, push_data, pop, head_data, empty, full, count.
  - Asynchronous active-high reset.
- Top level contains the credit/inflight counter, the drain counter, the issue register and the err logic.

Test Plan:
1. Reset release -> in_ready = 0 for exactly LAT+1 = 6 cycles, then 1. mul_start = 0 and err = 0 throughout; busy = 1 during the drain.
2. Single op, in_a = in_b = 0x40000000 (1.0), accepted at edge t:
   - mul_start = 1 with mul_in1 = mul_in2 = 0x40000000 in cycle t+1 only.
   - Bench multiplier model returns done in cycle t+6 with out = 0x40000000.
   - out_valid = 1 with out_data = 0x40000000, inf = 0, zero = 0 from cycle t+7.
3. out_ready = 0, present 10 ops back-to-back -> exactly 8 accepted, in_ready = 0 afterwards, err = 0.
   - Then out_ready = 1 -> 8 results popped in issue order, and in_ready returns to 1.
4. out_ready = 1, 20 consecutive ops -> in_ready stays 1, 20 results in issue order at one per cycle.
   - Include in_a = 0 and in_b = 0 -> out_zero = 1, data 0.
   - Include in_a = 0x80000000 -> out_inf = 1, data 0x80000000.
5. Idle (inflight = 0, drain = 0), inject mul_done = 1 with out = 0x12345678 -> err = 1 and stays 1; out_valid stays 0.
6. Three ops in flight, pulse rst for 1 cycle -> the bench multiplier's 3 pending done pulses are all dropped, out_valid stays 0, err = 0, and in_ready = 1 six cycles after release.
